keypad_digit_decoder: RTL and testbench

//   Classifies a 4-bit keypad keycode, qualified by a key strobe, as a decimal digit (0-9) or an operator key (10-15).
//   For a digit it presents the digit value; for an operator it presents an operator index.

---
 rtl/keypad_digit_decoder.sv | 55 +++++
 tb/tb_keypad_digit_decoder.sv | 135 +++++++++++++
 2 files changed

// File: rtl/keypad_digit_decoder.sv
// Classifies a strobed 4-bit keycode as a digit (0-9) or an operator (10-15).
// Latency: 1 clock, registered outputs; one decode result per strobed cycle.
// Backpressure: none, every strobed cycle is decoded and non-strobed cycles zero the outputs.
module keypad_digit_decoder (
    input  logic       clk,
    input  logic       nrst,
    input  logic       keystrobe,
    input  logic [3:0] keycode,
    output logic       isdig,
    output logic [3:0] digitCode,
    output logic       isop,
    output logic [2:0] opCode
);

    logic       dig_nxt;
    logic       op_nxt;
    logic [3:0] digit_nxt;
    logic [2:0] op_nxt_code;
    logic [3:0] op_offset;

    // Offset from the lowest operator key; only the 3 LSBs are meaningful for 10..15.
    assign op_offset = keycode - 4'd10;

    // Unstrobed cycles force every field to zero so an undriven keycode cannot leak through.
    always_comb begin
        dig_nxt     = 1'b0;
        op_nxt      = 1'b0;
        digit_nxt   = 4'd0;
        op_nxt_code = 3'd0;
        if (keystrobe) begin
            if (keycode <= 4'd9) begin
                dig_nxt   = 1'b1;
                digit_nxt = keycode;
            end else begin
                op_nxt      = 1'b1;
                op_nxt_code = op_offset[2:0];
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            isdig     <= 1'b0;
            digitCode <= 4'd0;
            isop      <= 1'b0;
            opCode    <= 3'd0;
        end else begin
            isdig     <= dig_nxt;
            digitCode <= digit_nxt;
            isop      <= op_nxt;
            opCode    <= op_nxt_code;
        end
    end

endmodule

// File: tb/tb_keypad_digit_decoder.sv
// Directed and randomized checks of keypad_digit_decoder against an arithmetic reference model.
module tb_keypad_digit_decoder;

    logic       clk;
    logic       nrst;
    logic       keystrobe;
    logic [3:0] keycode;
    logic       isdig;
    logic [3:0] digitCode;
    logic       isop;
    logic [2:0] opCode;

    int n_asserts = 0;
    int n_fail    = 0;

    keypad_digit_decoder dut (
        .clk       (clk),
        .nrst      (nrst),
        .keystrobe (keystrobe),
        .keycode   (keycode),
        .isdig     (isdig),
        .digitCode (digitCode),
        .isop      (isop),
        .opCode    (opCode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input logic e_dig, input logic [3:0] e_dc,
                         input logic e_op, input logic [2:0] e_oc, input string tag);
        n_asserts++;
        assert (isdig === e_dig) else begin
            n_fail++;
            $error("FAIL %s isdig observed=%b expected=%b", tag, isdig, e_dig);
        end
        n_asserts++;
        assert (digitCode === e_dc) else begin
            n_fail++;
            $error("FAIL %s digitCode observed=%0d expected=%0d", tag, digitCode, e_dc);
        end
        n_asserts++;
        assert (isop === e_op) else begin
            n_fail++;
            $error("FAIL %s isop observed=%b expected=%b", tag, isop, e_op);
        end
        n_asserts++;
        assert (opCode === e_oc) else begin
            n_fail++;
            $error("FAIL %s opCode observed=%0d expected=%0d", tag, opCode, e_oc);
        end
    endtask

    // Reference: digits are keys below ten, operators are numbered from key ten upward.
    task automatic step(input logic s, input logic [3:0] k, input string tag);
        int  kv;
        logic e_dig, e_op;
        logic [3:0] e_dc;
        logic [2:0] e_oc;
        keystrobe = s;
        keycode   = k;
        @(posedge clk);
        @(negedge clk);
        e_dig = 1'b0; e_op = 1'b0; e_dc = 4'd0; e_oc = 3'd0;
        kv = int'(k);
        if (s === 1'b1) begin
            if (kv < 10) begin
                e_dig = 1'b1;
                e_dc  = 4'(kv);
            end else begin
                e_op = 1'b1;
                e_oc = 3'(kv - 10);
            end
        end
        check(e_dig, e_dc, e_op, e_oc, tag);
    endtask

    initial begin
        logic [3:0] seq_off [5];
        logic [3:0] seq_dig [4];
        logic [3:0] seq_op  [3];
        seq_off = '{4'd10, 4'd3, 4'd9, 4'd7, 4'd11};
        seq_dig = '{4'd9, 4'd1, 4'd2, 4'd8};
        seq_op  = '{4'd10, 4'd12, 4'd15};

        // Reset holds outputs at zero even with a strobed key present.
        nrst      = 1'b0;
        keystrobe = 1'b1;
        keycode   = 4'd5;
        repeat (2) @(negedge clk);
        check(1'b0, 4'd0, 1'b0, 3'd0, "reset_hold");
        nrst = 1'b1;
        #1 check(1'b0, 4'd0, 1'b0, 3'd0, "release_before_edge");
        @(negedge clk);
        check(1'b1, 4'd5, 1'b0, 3'd0, "first_decode");

        foreach (seq_off[i]) step(1'b0, seq_off[i], "strobe_low");
        step(1'b0, 4'bxxxx, "strobe_low_x");
        foreach (seq_dig[i]) step(1'b1, seq_dig[i], "digit");
        foreach (seq_op[i])  step(1'b1, seq_op[i], "operator");
        step(1'b1, 4'd0, "digit_zero");
        step(1'b0, 4'd5, "after_zero_low");
        step(1'b1, 4'd9, "boundary_9");
        step(1'b1, 4'd10, "boundary_10");

        // Mid-cycle asynchronous reset.
        step(1'b1, 4'd4, "pre_reset_digit");
        #2 nrst = 1'b0;
        #1 check(1'b0, 4'd0, 1'b0, 3'd0, "async_reset_immediate");
        @(posedge clk);
        @(negedge clk);
        check(1'b0, 4'd0, 1'b0, 3'd0, "async_reset_held");
        nrst = 1'b1;
        keystrobe = 1'b0;
        @(negedge clk);

        // Randomized stream, including long strobe runs with changing codes.
        for (int i = 0; i < 300; i++) begin
            logic s;
            logic [3:0] k;
            s = ($urandom_range(0, 3) != 0);
            k = 4'($urandom_range(0, 15));
            step(s, k, "random");
            n_asserts++;
            assert (!(isdig === 1'b1 && isop === 1'b1)) else begin
                n_fail++;
                $error("FAIL exclusive isdig=%b isop=%b expected not both high", isdig, isop);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
